dmem_port_arb: RTL and testbench
================================

# dmem_port_arb

Round-robin arbiter that shares one synchronous-read port of the data memory between two requesters. Requesters are, for example, the two load/store units of the dual-issue core, or one LSU and the program loader. It sits between the requesters and one port (A or B) of the dual-port data RAM. It drives that port's clock-enable, word address, write data and byte write mask. It returns read data to the winning requester one cycle after the grant.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of requester and memory address buses.
- DATA_W, 32, data width; byte mask width is DATA_W/8.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- r0_req  in  1  requester 0 access request.
- r0_addr  in  ADDR_W  requester 0 byte address.
- r0_wdata  in  DATA_W  requester 0 write data.
- r0_wmask  in  DATA_W/8  requester 0 byte write mask; all-zero means read.
- r0_gnt  out  1  request accepted this cycle.
- r0_rvalid  out  1  read data valid for requester 0.
- r0_rdata  out  DATA_W  read data for requester 0.
- r1_req, r1_addr, r1_wdata, r1_wmask, r1_gnt, r1_rvalid, r1_rdata: same as requester 0, for requester 1.
- m_cen  out  1  memory port clock enable.
- m_addr  out  ADDR_W  byte address to memory; the memory uses bits [15:2].
- m_wdata  out  DATA_W  memory write data.
- m_wmask  out  DATA_W/8  memory byte write mask; write enable is the OR of the mask.
- m_rdata  in  DATA_W  memory read data, registered, valid 1 cycle after m_cen.

## Operation
- Registered state:
  - prio: next-preferred requester.
  - rd_pend[1:0]: read-issued flags, one per requester.
  - Optional lock owner (see Configuration).
- Arbitration is combinational from registered state:
  - Only one requester asserting req: it wins.
  - Both asserting req: prio wins.
- Grant:
  - Winner gets gnt=1 the same cycle.
  - m_cen=1 and m_addr/m_wdata/m_wmask are taken from the winner.
  - No req asserted: m_cen=0, m_wmask=0, address and data don't-care.
- After any grant, prio becomes the non-winning requester. prio is unchanged on idle cycles.
- Read vs write:
  - A grant with wmask==0 is a read and sets that requester's rd_pend bit for the next cycle.
  - A write's only acknowledge is gnt; it produces no rvalid.
- Read return:
  - rN_rvalid = rd_pend[N], registered.
  - rN_rdata = m_rdata while rN_rvalid=1, and 0 otherwise.
- Requester contract: hold req, addr, wdata and wmask stable until gnt. Fields may change in the cycle after gnt.
- Back-to-back grants are allowed every cycle, so throughput is 1 access/cycle.

## Timing
- Reset values: prio=0, rd_pend=0, lock owner cleared, r0_rvalid=r1_rvalid=0, rdata=0.
- gnt, m_cen and m_* outputs during reset are all 0.
- Grant latency is 0 cycles from req, combinational.
- Read-data latency is exactly 1 cycle after gnt.
- Write to address X granted in cycle t, read of X granted in t+1: the read returns the new data. This follows from memory write-then-read ordering; the arbiter does no forwarding.
- Simultaneous requests on consecutive cycles alternate strictly: 0,1,0,1…
- A reset asserted in the cycle after a read grant suppresses that rvalid; reset has priority over all state updates.

## Configuration
- DMEM_ARB_LOCK_EN defined:
  - Adds inputs r0_lock and r1_lock (1 bit each).
  - A granted requester with lock=1 becomes lock owner.
  - While an owner exists, only the owner can be granted. The other requester waits, whatever prio says.
  - Ownership is released at the first owner grant with lock=0, or on reset.
  - This enables atomic read-modify-write sequences.
  - prio still updates after each grant.
- DMEM_ARB_LOCK_EN undefined: no lock ports and no lock state; plain round-robin.

## Test plan
- Reset: assert reset with both req=1 -> gnt=0, m_cen=0, rvalid=0; after release, r0 wins first.
- Contention: both req=1 for 4 cycles, all reads, addresses 0x100 (r0) and 0x200 (r1) -> grants 0,1,0,1. Each rvalid is 1 cycle after its grant, with the data preloaded at words 0x40/0x80.
- Write then read: r1 writes 0xDEADBEEF mask 4'b1111 to 0x10, then reads 0x10 next cycle -> r1_rvalid with 0xDEADBEEF, r0_rvalid stays 0.
- Byte mask: r0 writes 0x000000AA mask 4'b0001 over word 0x11223344, then reads -> 0x112233AA.
- Single requester: r0_req held 3 cycles -> gnt every cycle, r1_gnt=0, prio ends at 1.
- Lock (DMEM_ARB_LOCK_EN): r0 reads with lock=1 while r1_req=1. r0 then writes with lock=0 -> r1 gets no grant until the cycle after r0's unlocking write.

Source files
------------

// File: rtl/dmem_port_arb_if.sv
// Requester channel of dmem_port_arb: request/address/write fields toward the
// arbiter, grant and read return back to the requester.
// Optional macro DMEM_ARB_LOCK_EN adds the per-requester lock signal.
interface dmem_port_arb_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  req;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wmask;
`ifdef DMEM_ARB_LOCK_EN
    logic                  lock;
`endif
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

`ifdef DMEM_ARB_LOCK_EN
    modport master (output req, addr, wdata, wmask, lock, input gnt, rvalid, rdata);
    modport slave  (input req, addr, wdata, wmask, lock, output gnt, rvalid, rdata);
`else
    modport master (output req, addr, wdata, wmask, input gnt, rvalid, rdata);
    modport slave  (input req, addr, wdata, wmask, output gnt, rvalid, rdata);
`endif
endinterface

// File: rtl/dmem_port_arb.sv
// Two-requester round-robin arbiter in front of one synchronous-read data
// memory port. Grants are combinational from registered priority; read data
// returns to the winner one cycle after its grant.
// Optional macro DMEM_ARB_LOCK_EN: adds lock ownership for atomic sequences.
module dmem_port_arb #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    dmem_port_arb_if.slave      r0,
    dmem_port_arb_if.slave      r1,
    output logic                m_cen,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wmask,
    input  logic [DATA_W-1:0]   m_rdata
);
    localparam int unsigned MaskW = DATA_W / 8;

    logic       prio_q, prio_d;
    logic [1:0] rd_pend_q, rd_pend_d;
    logic       elig0, elig1;
    logic       gnt0, gnt1;

`ifdef DMEM_ARB_LOCK_EN
    logic lock_vld_q, lock_vld_d;
    logic lock_own_q, lock_own_d;
`endif

    // Arbitration: eligible requesters, then priority tie-break; nothing granted in reset.
    always_comb begin
        elig0 = r0.req;
        elig1 = r1.req;
`ifdef DMEM_ARB_LOCK_EN
        // A current lock owner excludes the other requester regardless of prio.
        if (lock_vld_q) begin
            elig0 = r0.req && !lock_own_q;
            elig1 = r1.req && lock_own_q;
        end
`endif
        gnt0 = !reset && elig0 && (!elig1 || !prio_q);
        gnt1 = !reset && elig1 && (!elig0 || prio_q);
    end

    // Memory port drive and grant outputs from the winner.
    always_comb begin
        r0.gnt  = gnt0;
        r1.gnt  = gnt1;
        m_cen   = gnt0 || gnt1;
        m_addr  = '0;
        m_wdata = '0;
        m_wmask = '0;
        if (gnt0) begin
            m_addr  = r0.addr;
            m_wdata = r0.wdata;
            m_wmask = r0.wmask;
        end else if (gnt1) begin
            m_addr  = r1.addr;
            m_wdata = r1.wdata;
            m_wmask = r1.wmask;
        end
    end

    // Next-state: priority flips to the loser, reads mark a pending return.
    always_comb begin
        prio_d = prio_q;
        if (gnt0) begin
            prio_d = 1'b1;
        end else if (gnt1) begin
            prio_d = 1'b0;
        end
        rd_pend_d[0] = gnt0 && (r0.wmask == {MaskW{1'b0}});
        rd_pend_d[1] = gnt1 && (r1.wmask == {MaskW{1'b0}});
`ifdef DMEM_ARB_LOCK_EN
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        if (gnt0) begin
            lock_vld_d = r0.lock;
            lock_own_d = 1'b0;
        end else if (gnt1) begin
            lock_vld_d = r1.lock;
            lock_own_d = 1'b1;
        end
`endif
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q    <= 1'b0;
            rd_pend_q <= 2'b00;
        end else begin
            prio_q    <= prio_d;
            rd_pend_q <= rd_pend_d;
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    // Lock ownership registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_vld_q <= 1'b0;
            lock_own_q <= 1'b0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
        end
    end
`endif

    // Read return; reset masks a return that was already registered.
    always_comb begin
        r0.rvalid = rd_pend_q[0] && !reset;
        r1.rvalid = rd_pend_q[1] && !reset;
        r0.rdata  = r0.rvalid ? m_rdata : '0;
        r1.rdata  = r1.rvalid ? m_rdata : '0;
    end
endmodule

// File: tb/tb_dmem_port_arb.sv
module tb_dmem_port_arb;
    logic        clk;
    logic        reset;
    logic        m_cen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    logic [31:0] m_rdata;

    int total;
    int bad;

    logic [31:0] mem [0:16383];

    dmem_port_arb_if #(.ADDR_W(32), .DATA_W(32)) r0_if ();
    dmem_port_arb_if #(.ADDR_W(32), .DATA_W(32)) r1_if ();

    dmem_port_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .r0      (r0_if),
        .r1      (r1_if),
        .m_cen   (m_cen),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wmask (m_wmask),
        .m_rdata (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous RAM, word-indexed by address bits [15:2].
    always @(posedge clk) begin
        if (m_cen) begin
            if (m_wmask == 4'b0000) begin
                m_rdata <= mem[m_addr[15:2]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (m_wmask[b]) mem[m_addr[15:2]][8*b +: 8] <= m_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic set_r0(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic lock);
        r0_if.req   = req;
        r0_if.addr  = addr;
        r0_if.wdata = wdata;
        r0_if.wmask = wmask;
`ifdef DMEM_ARB_LOCK_EN
        r0_if.lock  = lock;
`else
        if (lock) ;
`endif
    endtask

    task automatic set_r1(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic lock);
        r1_if.req   = req;
        r1_if.addr  = addr;
        r1_if.wdata = wdata;
        r1_if.wmask = wmask;
`ifdef DMEM_ARB_LOCK_EN
        r1_if.lock  = lock;
`else
        if (lock) ;
`endif
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_r0(1'b1, 32'h100, 32'h0, 4'h0, 1'b0);
        set_r1(1'b1, 32'h200, 32'h0, 4'h0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if ({r0_if.gnt, r1_if.gnt} !== 2'b00) begin
                bad++; $display("FAIL reset_gnt: got %b want 00", {r0_if.gnt, r1_if.gnt});
            end
            total++;
            if (m_cen !== 1'b0 || m_wmask !== 4'h0) begin
                bad++; $display("FAIL reset_mem: cen=%b wmask=%h want 0/0", m_cen, m_wmask);
            end
            total++;
            if ({r0_if.rvalid, r1_if.rvalid} !== 2'b00 || r0_if.rdata !== 32'h0) begin
                bad++;
                $display("FAIL reset_rvalid: got %b rdata=%h want 00/0",
                         {r0_if.rvalid, r1_if.rvalid}, r0_if.rdata);
            end
            next_cycle();
        end
        reset = 1'b0;
        set_r0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_r1(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        total++;
        if ({r0_if.rvalid, r1_if.rvalid} !== 2'b00 || m_cen !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: rvalid=%b cen=%b want 00/0",
                     {r0_if.rvalid, r1_if.rvalid}, m_cen);
        end
        next_cycle();
    endtask

    // Expects prio=0 on entry (fresh out of reset).
    task automatic test_contention();
        logic        w;
        logic        prev_w;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        set_r0(1'b1, 32'h100, 32'h0, 4'h0, 1'b0);
        set_r1(1'b1, 32'h200, 32'h0, 4'h0, 1'b0);
        prev_w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = (i % 2) == 1;
            exp_addr = w ? 32'h200 : 32'h100;
            @(negedge clk);
            total++;
            if (r0_if.gnt !== !w || r1_if.gnt !== w) begin
                bad++;
                $display("FAIL contention_gnt[%0d]: got %b%b want %b%b", i, r1_if.gnt, r0_if.gnt,
                         w, !w);
            end
            total++;
            if (m_cen !== 1'b1 || m_addr !== exp_addr || m_wmask !== 4'h0) begin
                bad++;
                $display("FAIL contention_mem[%0d]: cen=%b addr=%h wmask=%h want 1/%h/0", i, m_cen,
                         m_addr, m_wmask, exp_addr);
            end
            if (i > 0) begin
                exp_data = prev_w ? 32'hB0B0_0080 : 32'hA0A0_0040;
                total++;
                if (r0_if.rvalid !== !prev_w || r1_if.rvalid !== prev_w) begin
                    bad++;
                    $display("FAIL contention_rvalid[%0d]: got %b%b want %b%b", i, r1_if.rvalid,
                             r0_if.rvalid, prev_w, !prev_w);
                end
                total++;
                if ((prev_w ? r1_if.rdata : r0_if.rdata) !== exp_data) begin
                    bad++;
                    $display("FAIL contention_rdata[%0d]: got %h want %h", i,
                             prev_w ? r1_if.rdata : r0_if.rdata, exp_data);
                end
            end
            prev_w = w;
            next_cycle();
        end
        set_r0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_r1(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        total++;
        if (r1_if.rvalid !== 1'b1 || r1_if.rdata !== 32'hB0B0_0080 || r0_if.rvalid !== 1'b0) begin
            bad++;
            $display("FAIL contention_last: r1 rvalid=%b rdata=%h r0 rvalid=%b want 1/b0b00080/0",
                     r1_if.rvalid, r1_if.rdata, r0_if.rvalid);
        end
        total++;
        if (m_cen !== 1'b0 || m_wmask !== 4'h0) begin
            bad++; $display("FAIL idle_mem: cen=%b wmask=%h want 0/0", m_cen, m_wmask);
        end
        next_cycle();
    endtask

    task automatic test_write_read();
        set_r1(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
        @(negedge clk);
        total++;
        if (r1_if.gnt !== 1'b1 || m_wmask !== 4'hF || m_wdata !== 32'hDEAD_BEEF ||
            m_addr !== 32'h10) begin
            bad++;
            $display("FAIL wr_issue: gnt=%b wmask=%h wdata=%h addr=%h want 1/f/deadbeef/10",
                     r1_if.gnt, m_wmask, m_wdata, m_addr);
        end
        next_cycle();
        set_r1(1'b1, 32'h10, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        total++;
        if (r1_if.gnt !== 1'b1 || r1_if.rvalid !== 1'b0) begin
            bad++;
            $display("FAIL wr_no_rvalid: gnt=%b rvalid=%b want 1/0", r1_if.gnt, r1_if.rvalid);
        end
        next_cycle();
        set_r1(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        total++;
        if (r1_if.rvalid !== 1'b1 || r1_if.rdata !== 32'hDEAD_BEEF || r0_if.rvalid !== 1'b0) begin
            bad++;
            $display("FAIL wr_readback: r1 rvalid=%b rdata=%h r0 rvalid=%b want 1/deadbeef/0",
                     r1_if.rvalid, r1_if.rdata, r0_if.rvalid);
        end
        next_cycle();
    endtask

    task automatic test_byte_mask();
        set_r0(1'b1, 32'h20, 32'h0000_00AA, 4'b0001, 1'b0);
        @(negedge clk);
        total++;
        if (r0_if.gnt !== 1'b1 || m_wmask !== 4'b0001) begin
            bad++; $display("FAIL bm_issue: gnt=%b wmask=%b want 1/0001", r0_if.gnt, m_wmask);
        end
        next_cycle();
        set_r0(1'b1, 32'h20, 32'h0, 4'h0, 1'b0);
        next_cycle();
        set_r0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        total++;
        if (r0_if.rvalid !== 1'b1 || r0_if.rdata !== 32'h1122_33AA) begin
            bad++;
            $display("FAIL bm_readback: rvalid=%b rdata=%h want 1/112233aa", r0_if.rvalid,
                     r0_if.rdata);
        end
        next_cycle();
    endtask

    // Read granted, reset in the following cycle must hide the return.
    task automatic test_reset_suppress();
        set_r0(1'b1, 32'h100, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        total++;
        if (r0_if.gnt !== 1'b1) begin
            bad++; $display("FAIL rs_gnt: got %b want 1", r0_if.gnt);
        end
        next_cycle();
        reset = 1'b1;
        set_r0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        total++;
        if (r0_if.rvalid !== 1'b0 || r0_if.rdata !== 32'h0) begin
            bad++;
            $display("FAIL rs_suppress: rvalid=%b rdata=%h want 0/0", r0_if.rvalid, r0_if.rdata);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (r0_if.rvalid !== 1'b0) begin
            bad++; $display("FAIL rs_after: rvalid=%b want 0", r0_if.rvalid);
        end
        next_cycle();
    endtask

    // Expects prio=0 on entry (after test_reset_suppress).
    task automatic test_single();
        set_r0(1'b1, 32'h100, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (r0_if.gnt !== 1'b1 || r1_if.gnt !== 1'b0) begin
                bad++;
                $display("FAIL single_gnt[%0d]: r0=%b r1=%b want 1/0", i, r0_if.gnt, r1_if.gnt);
            end
            if (i > 0) begin
                total++;
                if (r0_if.rvalid !== 1'b1 || r0_if.rdata !== 32'hA0A0_0040) begin
                    bad++;
                    $display("FAIL single_rdata[%0d]: rvalid=%b rdata=%h want 1/a0a00040", i,
                             r0_if.rvalid, r0_if.rdata);
                end
            end
            next_cycle();
        end
        // prio now 1: contention goes to r1 first, then r0.
        set_r1(1'b1, 32'h200, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        total++;
        if (r0_if.gnt !== 1'b0 || r1_if.gnt !== 1'b1) begin
            bad++;
            $display("FAIL single_prio: r0=%b r1=%b want 0/1", r0_if.gnt, r1_if.gnt);
        end
        next_cycle();
        set_r1(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        total++;
        if (r0_if.gnt !== 1'b1 || r1_if.rvalid !== 1'b1 || r1_if.rdata !== 32'hB0B0_0080) begin
            bad++;
            $display("FAIL single_after: r0 gnt=%b r1 rvalid=%b rdata=%h want 1/1/b0b00080",
                     r0_if.gnt, r1_if.rvalid, r1_if.rdata);
        end
        next_cycle();
        set_r0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        next_cycle();
    endtask

`ifdef DMEM_ARB_LOCK_EN
    task automatic test_lock();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        set_r0(1'b1, 32'h100, 32'h0, 4'h0, 1'b1);
        set_r1(1'b1, 32'h200, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        total++;
        if (r0_if.gnt !== 1'b1 || r1_if.gnt !== 1'b0) begin
            bad++; $display("FAIL lock_take: r0=%b r1=%b want 1/0", r0_if.gnt, r1_if.gnt);
        end
        next_cycle();
        set_r0(1'b1, 32'h30, 32'h5, 4'hF, 1'b0);
        @(negedge clk);
        total++;
        if (r0_if.gnt !== 1'b1 || r1_if.gnt !== 1'b0) begin
            bad++; $display("FAIL lock_hold: r0=%b r1=%b want 1/0", r0_if.gnt, r1_if.gnt);
        end
        next_cycle();
        set_r0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        total++;
        if (r1_if.gnt !== 1'b1) begin
            bad++; $display("FAIL lock_release: r1=%b want 1", r1_if.gnt);
        end
        next_cycle();
        set_r1(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        next_cycle();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[32'h40] = 32'hA0A0_0040;
        mem[32'h80] = 32'hB0B0_0080;
        mem[8]      = 32'h1122_3344;
        set_r0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_r1(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        reset = 1'b1;
        #1;
        test_reset();
        test_contention();
        test_write_read();
        test_byte_mask();
        test_reset_suppress();
        test_single();
`ifdef DMEM_ARB_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
